// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the single-clock FIFO.
// The FIFO depth and the occupancy-counter width come from ADDRSIZE.
// Every sync_fifo file imports this package.
package sync_fifo_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 4;

  // The number of storage words addressed by an ADDRSIZE-bit pointer.
  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  // The occupancy counter must hold 0..DEPTH, so it needs one bit more than the pointers.
  function automatic int fifo_level_w(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle of sync_fifo.
// The master modport is the producer/consumer side.
// The slave modport is the FIFO itself.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE
);

  logic                              winc;
  logic [DATASIZE-1:0]               wdata;
  logic                              wfull;
  logic                              awfull;
  logic                              rinc;
  logic [DATASIZE-1:0]               rdata;
  logic                              rempty;
  logic                              arempty;
  logic [fifo_level_w(ADDRSIZE)-1:0] level;
  logic                              clr_err;
  logic                              ovf;
  logic                              udf;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  wfull, awfull, rdata, rempty, arempty, level, ovf, udf
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output wfull, awfull, rdata, rempty, arempty, level, ovf, udf
  );

endinterface

// File: rtl/sync_fifo_fifomem.sv
// Module fifomem: dual-port storage array plus the FIFO read path.
// With FALLTHROUGH="TRUE", the read port is combinational (first-word fall-through).
// With "FALSE", rdata is a register that loads only on an accepted read.
// The storage array has no reset. Only the rdata register is reset.
module fifomem
  import sync_fifo_pkg::*;
#(
  parameter int    DATASIZE    = DEF_DATASIZE,
  parameter int    ADDRSIZE    = DEF_ADDRSIZE,
  parameter string FALLTHROUGH = "TRUE"
) (
  input  logic                wclk,
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                wclken,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rclken,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam bit FT    = (FALLTHROUGH == "TRUE");

  logic [DATASIZE-1:0] r_mem [DEPTH];

  // Write port: store the word at the write pointer when the top accepts a write
  always_ff @(posedge wclk) begin
    if (wclken) begin
      r_mem[waddr] <= wdata;
    end
  end

  if (FT) begin : g_fallthrough
    // Head of queue is always presented; the read strobe and reset play no part here.
    logic w_unused_rd;
    assign w_unused_rd = rclk ^ rclken ^ rst_n;

    // Combinational read: the word at the read pointer is the next to be popped
    always_comb begin
      rdata = r_mem[raddr];
    end
  end else begin : g_registered
    logic [DATASIZE-1:0] r_rdata;

    // Registered read: capture the popped word and hold it until the next accepted read
    always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
        r_rdata <= '0;
      end else if (rclken) begin
        r_rdata <= r_mem[raddr];
      end
    end

    assign rdata = r_rdata;
  end

endmodule

// File: rtl/sync_fifo.sv
// Top level of the single-clock FIFO.
// It holds the write/read pointers, the occupancy counter and the status flag decode.
// Optional feature: define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags.
// Without SYNC_FIFO_ERR_EN, ovf/udf are tied low and clr_err is ignored.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int    DATASIZE      = DEF_DATASIZE,
  parameter int    ADDRSIZE      = DEF_ADDRSIZE,
  parameter string FALLTHROUGH   = "TRUE",
  parameter int    AFULL_THRESH  = 14,
  parameter int    AEMPTY_THRESH = 2
) (
  input logic        clk,
  input logic        rst_n,
  sync_fifo_if.slave bus
);

  localparam int DEPTH   = fifo_depth(ADDRSIZE);
  localparam int LEVEL_W = fifo_level_w(ADDRSIZE);

  logic [ADDRSIZE-1:0] r_wptr;
  logic [ADDRSIZE-1:0] r_rptr;
  logic [LEVEL_W-1:0]  r_level;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode the level register only.
  // They therefore settle the cycle after an access, with no combinational path from winc/rinc.
  assign w_full  = (r_level == LEVEL_W'(DEPTH));
  assign w_empty = (r_level == '0);

  // A full FIFO still accepts a read, and an empty one still accepts a write.
  // This makes the simultaneous-access corner cases fall out naturally.
  assign w_wr_acc = bus.winc && !w_full;
  assign w_rd_acc = bus.rinc && !w_empty;

  // Pointer update: each pointer wraps through DEPTH-1 -> 0 by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + ADDRSIZE'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + ADDRSIZE'(1);
      end
    end
  end

  // Occupancy: moves only when exactly one side of the FIFO is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.level   = r_level;
  assign bus.wfull   = w_full;
  assign bus.rempty  = w_empty;
  assign bus.awfull  = (r_level >= LEVEL_W'(AFULL_THRESH));
  assign bus.arempty = (r_level <= LEVEL_W'(AEMPTY_THRESH));

  fifomem #(
    .DATASIZE   (DATASIZE),
    .ADDRSIZE   (ADDRSIZE),
    .FALLTHROUGH(FALLTHROUGH)
  ) u_fifomem (
    .wclk  (clk),
    .rclk  (clk),
    .rst_n (rst_n),
    .wclken(w_wr_acc),
    .waddr (r_wptr),
    .wdata (bus.wdata),
    .rclken(w_rd_acc),
    .raddr (r_rptr),
    .rdata (bus.rdata)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Sticky error capture: a fresh error in the clearing cycle keeps its flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.winc && w_full) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_err) begin
        r_ovf <= 1'b0;
      end
      if (bus.rinc && w_empty) begin
        r_udf <= 1'b1;
      end else if (bus.clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;
`else
  logic w_unused_clr;
  assign w_unused_clr = bus.clr_err;

  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo.
// One fall-through instance is checked against a queue scoreboard and a level/flag model.
// A second instance with a registered read covers the registered read path.
module tb_sync_fifo;

  localparam int DEPTH = 16;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] sb[$];
  logic       mdl_ovf = 1'b0;
  logic       mdl_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATASIZE(8), .ADDRSIZE(4)) bus ();
  sync_fifo_if #(.DATASIZE(8), .ADDRSIZE(4)) bus_r ();

  sync_fifo #(
    .DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("TRUE"),
    .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  sync_fifo #(
    .DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE"),
    .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u_dut_reg (
    .clk(clk), .rst_n(rst_n), .bus(bus_r.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.winc = 1'b0; bus.wdata = '0; bus.rinc = 1'b0; bus.clr_err = 1'b0;
    bus_r.winc = 1'b0; bus_r.wdata = '0; bus_r.rinc = 1'b0; bus_r.clr_err = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    int lvl;
    lvl = sb.size();
    check({tag, "_level"},   32'(bus.level), 32'(lvl));
    check({tag, "_rempty"},  32'(bus.rempty), 32'(lvl == 0));
    check({tag, "_wfull"},   32'(bus.wfull), 32'(lvl == DEPTH));
    check({tag, "_arempty"}, 32'(bus.arempty), 32'(lvl <= 2));
    check({tag, "_awfull"},  32'(bus.awfull), 32'(lvl >= 14));
    check({tag, "_ovf"},     32'(bus.ovf), 32'(mdl_ovf));
    check({tag, "_udf"},     32'(bus.udf), 32'(mdl_udf));
  endtask

  // One clock of traffic on the fall-through FIFO, with scoreboard and model update
  task automatic do_cycle(input string tag, input logic w, input logic [7:0] d,
                          input logic r, input logic c);
    logic       full, empty, wacc, racc;
    logic [7:0] exp;
    full  = (sb.size() == DEPTH);
    empty = (sb.size() == 0);
    wacc  = w && !full;
    racc  = r && !empty;
    bus.winc = w; bus.wdata = d; bus.rinc = r; bus.clr_err = c;
    if (racc) begin
      exp = sb.pop_front();
      check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp));
    end
    if (wacc) sb.push_back(d);
    if (ERR_EN) begin
      mdl_ovf = (w && full)  ? 1'b1 : (c ? 1'b0 : mdl_ovf);
      mdl_udf = (r && empty) ? 1'b1 : (c ? 1'b0 : mdl_udf);
    end
    tick();
    idle_inputs();
    check_flags(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    sb.delete();
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();

    // 1: reset state
    apply_reset();
    check_flags("rst");
    check("rst_reg_rdata", 32'(bus_r.rdata), 32'h0);
    check("rst_reg_rempty", 32'(bus_r.rempty), 32'h1);

    // 4: registered read path
    bus_r.winc = 1'b1; bus_r.wdata = 8'h3C;
    tick();
    bus_r.winc = 1'b0;
    check("reg_rempty_after_wr", 32'(bus_r.rempty), 32'h0);
    check("reg_rdata_before_rinc", 32'(bus_r.rdata), 32'h0);
    bus_r.rinc = 1'b1;
    tick();
    bus_r.rinc = 1'b0;
    check("reg_rdata_after_rinc", 32'(bus_r.rdata), 32'h3C);
    check("reg_rempty_after_rd", 32'(bus_r.rempty), 32'h1);
    repeat (3) begin
      tick();
      check("reg_rdata_hold", 32'(bus_r.rdata), 32'h3C);
    end
    bus_r.winc = 1'b1; bus_r.wdata = 8'h11;
    tick();
    bus_r.wdata = 8'h22;
    tick();
    bus_r.winc = 1'b0; bus_r.rinc = 1'b1;
    tick();
    bus_r.rinc = 1'b0;
    check("reg_rdata_w1", 32'(bus_r.rdata), 32'h11);
    tick();
    check("reg_rdata_w1_hold", 32'(bus_r.rdata), 32'h11);
    bus_r.rinc = 1'b1;
    tick();
    check("reg_rdata_w2", 32'(bus_r.rdata), 32'h22);
    tick();
    bus_r.rinc = 1'b0;
    check("reg_rdata_empty_rd", 32'(bus_r.rdata), 32'h22);

    // 2: fill 0x00..0x0F then drain in order
    for (int i = 0; i < DEPTH; i++) do_cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 3: simultaneous access at full and at empty
    for (int i = 0; i < DEPTH; i++) do_cycle("fill2", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    do_cycle("full_both", 1'b1, 8'hAA, 1'b1, 1'b0);
    check("full_both_level", 32'(bus.level), 32'd15);
    for (int i = 0; i < DEPTH - 1; i++) do_cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle("empty_both", 1'b1, 8'h55, 1'b1, 1'b0);
    check("empty_both_level", 32'(bus.level), 32'd1);
    check("empty_both_rdata", 32'(bus.rdata), 32'h55);
    do_cycle("pop55", 1'b0, 8'h00, 1'b1, 1'b1);

    // 5: random traffic with pointer wrap
    for (int i = 0; i < 40; i++) begin
      do_cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      check("rand_level_bound", 32'(bus.level <= 5'd16), 32'h1);
    end

    // 6: asynchronous reset mid-burst
    apply_reset();
    for (int i = 0; i < 9; i++) do_cycle("burst", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check("burst_level", 32'(bus.level), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(bus.level), 32'h0);
    check("async_rst_rempty", 32'(bus.rempty), 32'h1);
    sb.delete();
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_flags("post_rst");
    do_cycle("post_rst_wr", 1'b1, 8'h77, 1'b0, 1'b0);
    do_cycle("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Error flags: overflow, clear with a simultaneous set, clear, underflow
    for (int i = 0; i < DEPTH; i++) do_cycle("efill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    do_cycle("ovf_set", 1'b1, 8'hEE, 1'b0, 1'b0);
    do_cycle("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    do_cycle("ovf_clr_vs_set", 1'b1, 8'hEF, 1'b0, 1'b1);
    do_cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) do_cycle("edrain", 1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle("udf_set", 1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle("udf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    do_cycle("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
